// File: rtl/tx_fsrc_hole_gen_if.sv
// Hole-mask stream between the hole generator and tx_fsrc_make_holes.
interface tx_fsrc_hole_gen_if #(
  parameter int NUM_SAMPLES = 8
);
  logic                   holes_valid;
  logic                   holes_ready;
  logic [NUM_SAMPLES-1:0] holes_data;

  modport master (output holes_valid, output holes_data, input holes_ready);
  modport slave  (input holes_valid, input holes_data, output holes_ready);
endinterface

// File: rtl/tx_fsrc_hole_gen.sv
// Fractional phase accumulator producing one hole mask per output bus word
// for the TX sample-rate converter.
module tx_fsrc_hole_gen #(
  parameter int NUM_SAMPLES = 8,
  parameter int ACC_W       = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [ACC_W:0]       incr,
  input  logic [ACC_W-1:0]     init_phase,
  tx_fsrc_hole_gen_if.master   hif,
  output logic                 busy,
  output logic [31:0]          word_cnt,
  output logic [31:0]          sample_cnt
);
  localparam int SW = ACC_W + $clog2(NUM_SAMPLES + 1) + 1;
  localparam logic [ACC_W:0] FULL = {1'b1, {ACC_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  state_e                 state_q;
  logic [ACC_W-1:0]       acc_q;
  logic [ACC_W:0]         incr_q;
  logic                   valid_q;
  logic [NUM_SAMPLES-1:0] data_q;
  logic [31:0]            wcnt_q, scnt_q;

  logic [ACC_W:0]         incr_sat;
  logic [SW-1:0]          slot_s [NUM_SAMPLES+1];
  logic [NUM_SAMPLES-1:0] mask;
  logic [ACC_W-1:0]       acc_nxt;
  logic [31:0]            nonholes;
  logic                   accept;

  assign incr_sat = (incr > FULL) ? FULL : incr;

  // Each slot's phase is computed directly from acc so no slot depends on the
  // previous one's adder; a slot carries data when its integer part advances.
  assign slot_s[0] = SW'(acc_q);
  for (genvar j = 0; j < NUM_SAMPLES; j++) begin : g_slot
    assign slot_s[j+1] = SW'(acc_q) + SW'(incr_q) * SW'(j + 1);
    assign mask[j]     = (slot_s[j+1][SW-1:ACC_W] == slot_s[j][SW-1:ACC_W]);
  end

  assign acc_nxt  = slot_s[NUM_SAMPLES][ACC_W-1:0];
  assign nonholes = 32'($countones(~data_q));
  assign accept   = valid_q && hif.holes_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      incr_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '1;
      wcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      if (accept) begin
        wcnt_q <= wcnt_q + 32'd1;
        scnt_q <= scnt_q + nonholes;
      end
      case (state_q)
        IDLE: if (enable) begin
          incr_q  <= incr_sat;
          acc_q   <= init_phase;
          wcnt_q  <= '0;
          scnt_q  <= '0;
          state_q <= RUN;
        end
        RUN: if (!enable) begin
          if (hif.holes_ready) valid_q <= 1'b0;
          state_q <= STOP;
        end else if (!valid_q || hif.holes_ready) begin
          data_q  <= mask;
          acc_q   <= acc_nxt;
          valid_q <= 1'b1;
        end
        STOP: if (!valid_q || hif.holes_ready) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hif.holes_valid = valid_q;
  assign hif.holes_data  = data_q;
  assign busy            = (state_q != IDLE);
  assign word_cnt        = wcnt_q;
  assign sample_cnt      = scnt_q;
endmodule

// File: tb/tb_tx_fsrc_hole_gen.sv
// Directed + randomized bench for tx_fsrc_hole_gen against a global-slot-index
// phase model.
module tb_tx_fsrc_hole_gen;
  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [32:0] incr;
  logic [31:0] init_phase;
  logic        busy;
  logic [31:0] word_cnt, sample_cnt;

  tx_fsrc_hole_gen_if #(.NUM_SAMPLES(8)) hif ();

  tx_fsrc_hole_gen #(.NUM_SAMPLES(8), .ACC_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .incr       (incr),
    .init_phase (init_phase),
    .hif        (hif.master),
    .busy       (busy),
    .word_cnt   (word_cnt),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  longint unsigned m_init, m_inc;
  int              widx, mwords;
  logic [31:0]     msamp;
  bit              stall_q;
  logic [7:0]      prev_data;
  logic [7:0]      got [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Global slot n is data iff floor((init+(n+1)*inc)/2^32) moved past floor((init+n*inc)/2^32).
  function automatic logic [7:0] ref_mask(input int w);
    logic [7:0] m;
    longint unsigned n, a, b;
    for (int j = 0; j < 8; j++) begin
      n    = longint'(w * 8 + j);
      a    = (m_init + n * m_inc) >> 32;
      b    = (m_init + (n + 1) * m_inc) >> 32;
      m[j] = (a == b);
    end
    return m;
  endfunction

  task automatic model_start(input logic [31:0] ip, input logic [32:0] inc);
    m_init  = longint'(ip);
    m_inc   = (inc > 33'h1_0000_0000) ? 64'h1_0000_0000 : longint'(inc);
    widx    = 0;
    mwords  = 0;
    msamp   = 0;
    stall_q = 1'b0;
    got.delete();
  endtask

  // Called at a negedge: checks stall stability, drives ready, scores the
  // handshake that the coming posedge will complete.
  task automatic tick(input bit rdy);
    logic [7:0] exp;
    if (stall_q) begin
      chk("stall_valid", 32'(hif.holes_valid), 32'd1);
      chk("stall_data", 32'(hif.holes_data), 32'(prev_data));
    end
    hif.holes_ready = rdy;
    stall_q   = hif.holes_valid && !rdy;
    prev_data = hif.holes_data;
    if (hif.holes_valid && rdy) begin
      exp = ref_mask(widx);
      chk("mask", 32'(hif.holes_data), 32'(exp));
      widx++;
      mwords++;
      msamp += 32'(8 - $countones(exp));
      got.push_back(hif.holes_data);
    end
    @(negedge clk);
  endtask

  task automatic run_stream(input logic [31:0] ip, input logic [32:0] inc,
                            input int nwords, input bit rnd, input int lit_s);
    int cyc;
    model_start(ip, inc);
    init_phase = ip;
    incr       = inc;
    enable     = 1'b1;
    cyc = 0;
    while (got.size() < nwords && cyc < 2000) begin
      tick(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      cyc++;
    end
    chk("run_words", 32'(got.size()), 32'(nwords));
    chk("run_wcnt", word_cnt, 32'(mwords));
    chk("run_scnt", sample_cnt, msamp);
    if (lit_s >= 0) chk("run_scnt_lit", sample_cnt, 32'(lit_s));
    enable     = 1'b0;
    incr       = 33'h0_1234_5678;
    init_phase = 32'hDEAD_BEEF;
    cyc = 0;
    while (busy && cyc < 200) begin
      tick(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      cyc++;
    end
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_valid", 32'(hif.holes_valid), 32'd0);
    chk("stop_wcnt", word_cnt, 32'(mwords));
    chk("stop_scnt", sample_cnt, msamp);
    for (int i = 0; i < 3; i++) tick(1'b1);
    chk("idle_hold_wcnt", word_cnt, 32'(mwords));
    chk("idle_hold_scnt", sample_cnt, msamp);
  endtask

  initial begin
    int cyc;
    longint unsigned lit;
    resetn = 1'b0;
    enable = 1'b0;
    incr = '0;
    init_phase = '0;
    hif.holes_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(hif.holes_valid), 32'd0);
    chk("rst_data", 32'(hif.holes_data), 32'hFF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wcnt", word_cnt, 32'd0);
    chk("rst_scnt", sample_cnt, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // First word appears two edges after enable is sampled.
    init_phase = 32'h0;
    incr = 33'h0_8000_0000;
    enable = 1'b1;
    hif.holes_ready = 1'b0;
    @(negedge clk);
    chk("lat_e1_valid", 32'(hif.holes_valid), 32'd0);
    chk("lat_e1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lat_e2_valid", 32'(hif.holes_valid), 32'd1);
    chk("lat_e2_data", 32'(hif.holes_data), 32'h55);
    enable = 1'b0;
    hif.holes_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lat_idle", 32'(busy), 32'd0);

    run_stream(32'h0, 33'h0_8000_0000, 6, 1'b0, 24);
    chk("t1_first", 32'(got[0]), 32'h55);
    chk("t1_last", 32'(got[5]), 32'h55);

    run_stream(32'h0, 33'h0_4000_0000, 4, 1'b0, 8);
    chk("t2_w0", 32'(got[0]), 32'h77);
    chk("t2_w3", 32'(got[3]), 32'h77);

    run_stream(32'h0, 33'h1_0000_0000, 3, 1'b0, 24);
    chk("t3_full", 32'(got[1]), 32'h00);
    run_stream(32'h1234_0000, 33'h1_0000_0005, 3, 1'b0, 24);
    chk("t3_sat", 32'(got[2]), 32'h00);
    run_stream(32'h0, 33'h0, 3, 1'b0, 0);
    chk("t3_zero", 32'(got[2]), 32'hFF);

    run_stream(32'h8000_0000, 33'h0_8000_0000, 2, 1'b0, 8);
    chk("t4_phase", 32'(got[0]), 32'hAA);
    lit = (64'd24 * 64'h5555_5555) >> 32;
    run_stream(32'h0, 33'h0_5555_5555, 3, 1'b0, int'(lit));

    // Random rates and phases under random backpressure.
    run_stream($urandom, 33'($urandom), 40, 1'b1, -1);
    run_stream($urandom, 33'($urandom_range(1, 32'h0FFF_FFFF)), 40, 1'b1, -1);
    run_stream($urandom, {1'b1, 32'($urandom)}, 10, 1'b1, -1);

    // Drop enable while stalled: the pending word must survive and drain.
    model_start(32'h0, 33'h0_4000_0000);
    init_phase = 32'h0;
    incr = 33'h0_4000_0000;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0);
    chk("t6_busy_held", 32'(busy), 32'd1);
    chk("t6_valid_held", 32'(hif.holes_valid), 32'd1);
    cyc = 0;
    while (busy && cyc < 50) begin
      tick(1'b1);
      cyc++;
    end
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_wcnt", word_cnt, 32'(mwords));
    chk("t6_scnt", sample_cnt, msamp);

    // Reset in the middle of a stream.
    model_start(32'h0, 33'h0_8000_0000);
    init_phase = 32'h0;
    incr = 33'h0_8000_0000;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b1);
    resetn = 1'b0;
    #1;
    chk("mrst_valid", 32'(hif.holes_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_wcnt", word_cnt, 32'd0);
    chk("mrst_scnt", sample_cnt, 32'd0);
    chk("mrst_data", 32'(hif.holes_data), 32'hFF);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mrst_hold_wcnt", word_cnt, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Stream is usable again after reset.
    run_stream(32'h0, 33'h0_8000_0000, 3, 1'b0, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
